riscv_v_decode_lmul_sequencer: RTL and testbench
================================================

RISCV_V_DECODE_LMUL_SEQUENCER -- requirements
Module: riscv_v_decode_lmul_sequencer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 16: bytes per vector register; power of two, 16 or more.
REQ-002 SHALL have parameter MAX_LMUL, default 8: maximum register group size; power of two, 1 to 8.
REQ-003 SHALL derive localparams VL_W = clog2(DATA_BYTES*MAX_LMUL+1) and IDX_W = max(1, clog2(MAX_LMUL)).
REQ-004 SHALL use a single clock and a synchronous, active-low reset.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_vsew  in  3  element size: 0 to 4 selects 8, 16, 32, 64, 128 bits.
REQ-010 req_vlmul  in  2  group size: 0 to 3 selects LMUL 1, 2, 4, 8.
REQ-011 req_vl  in  VL_W  vector length, in elements.
REQ-012 req_vstart  in  VL_W  first active element.
REQ-013 req_use_mask  in  1  apply req_mask.
REQ-014 req_mask  in  DATA_BYTES*MAX_LMUL  one mask bit per global element index.
REQ-015 req_is_reduct  in  1  reduction destination (scalar result).
REQ-016 out_valid  out  1  beat present.
REQ-017 out_ready  in  1  consumer accepts the beat.
REQ-018 out_reg_idx  out  IDX_W  register offset within the group.
REQ-019 out_elem_valid  out  DATA_BYTES  byte-granular element valid.
REQ-020 out_merge  out  DATA_BYTES  bit b=1: byte b chains carry into byte b+1 of the same element.
REQ-021 out_osize  out  3  registered req_vsew.
REQ-022 out_last  out  1  final beat of the request.
REQ-023 out_illegal  out  1  request has req_vsew>4, or req_vlmul selects LMUL>MAX_LMUL.

Function
REQ-024 SHALL implement FSM IDLE/ISSUE: req_ready=1 only in IDLE; on req_valid&&req_ready, capture all req_* fields and go to ISSUE.
REQ-025 SHALL assert out_valid in the cycle after acceptance and throughout ISSUE (latency 1).
REQ-026 SHALL hold all out_* fields stable while out_valid&&!out_ready.
REQ-027 SHALL increment the beat counter on each out_valid&&out_ready; on the out_last handshake, SHALL go to IDLE, with req_ready=1 the next cycle; no same-cycle re-accept.
REQ-028 SHALL derive EPR = DATA_BYTES>>vsew, LMUL = 1<<vlmul, and vl_eff = min(vl, EPR*LMUL).
REQ-029 SHALL set beat count NB = clamp(ceil(vl_eff/EPR), 1, LMUL); out_reg_idx = beat counter; out_last = (counter == NB-1).
REQ-030 For element e of beat k, with g = k*EPR+e, SHALL treat the element as active iff vstart<=g<vl_eff and (!use_mask || mask[g]); all bytes of an active element SHALL be set in out_elem_valid.
REQ-031 out_merge SHALL set all bytes except the top byte of each element, independent of validity (32-bit: 4'b0111 per element).
REQ-032 If is_reduct, NB SHALL be 1 and only element 0 MAY be active (same rule as REQ-030).
REQ-033 If vl_eff==0 or vstart>=vl_eff, SHALL issue one beat with out_elem_valid=0 and out_last=1.
REQ-034 If illegal, SHALL issue one beat with out_illegal=1, out_elem_valid=0, out_merge=0, out_last=1.
REQ-035 MAX_LMUL sizes req_mask; mask bits at or above vl_eff SHALL be ignored.

Reset
REQ-036 While rst_n=0 at a clock edge, next state SHALL be IDLE with counter=0, out_valid=0, out_reg_idx=0, out_elem_valid=0, out_merge=0, out_osize=0, out_last=0, out_illegal=0, req_ready=1.
REQ-037 Reset mid-ISSUE SHALL drop the in-flight request with no further beats emitted.

Verification (DATA_BYTES=16, MAX_LMUL=8)
REQ-038 vsew=2, vlmul=1, vl=6, vstart=0, no mask -> beat0: idx0, valid 16'hFFFF, merge 16'h7777, last 0; beat1: idx1, valid 16'h00FF, last 1.
REQ-039 vsew=0, vlmul=0, vl=16, vstart=3, use_mask, mask[15:0]=16'h00FF -> one beat: valid 16'h00F8, merge 16'h0000, last 1.
REQ-040 vsew=3, vlmul=3, vl=5 -> three beats, idx 0/1/2, valid FFFF/FFFF/00FF, merge 16'h7F7F, last on idx 2 only.
REQ-041 out_ready held low 3 cycles on beat 0, req_valid pulsed meanwhile -> beat 0 fields stable, req_ready=0, second request not accepted.
REQ-042 vl=0, or vsew=5 -> single beat, valid 0, last 1; out_illegal 0 for vl=0, 1 for vsew=5.
REQ-043 rst_n low one cycle during beat 1 of REQ-038 -> next cycle out_valid=0, req_ready=1, and no beat 1 handshake ever.

Source files
------------

// File: rtl/riscv_v_decode_lmul_sequencer_if.sv
// Request/beat bundle between a vector decode front end and the LMUL sequencer.
//
// Handshake rules, both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised, the source keeps
// valid and every payload field stable until that transfer. Ready may change
// freely, and valid never waits on ready.
interface riscv_v_decode_lmul_sequencer_if #(
    parameter int DATA_BYTES = 16,
    parameter int MAX_LMUL   = 8
);
    localparam int VL_W  = $clog2(DATA_BYTES * MAX_LMUL + 1);
    localparam int IDX_W = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1;

    // request channel
    logic                           req_valid;
    logic                           req_ready;
    logic [2:0]                     req_vsew;
    logic [1:0]                     req_vlmul;
    logic [VL_W-1:0]                req_vl;
    logic [VL_W-1:0]                req_vstart;
    logic                           req_use_mask;
    logic [DATA_BYTES*MAX_LMUL-1:0] req_mask;
    logic                           req_is_reduct;

    // beat channel
    logic                           out_valid;
    logic                           out_ready;
    logic [IDX_W-1:0]               out_reg_idx;
    logic [DATA_BYTES-1:0]          out_elem_valid;
    logic [DATA_BYTES-1:0]          out_merge;
    logic [2:0]                     out_osize;
    logic                           out_last;
    logic                           out_illegal;

    // master: issues requests and consumes beats
    modport master (
        output req_valid, req_vsew, req_vlmul, req_vl, req_vstart,
               req_use_mask, req_mask, req_is_reduct, out_ready,
        input  req_ready, out_valid, out_reg_idx, out_elem_valid,
               out_merge, out_osize, out_last, out_illegal
    );

    // slave: the sequencer
    modport slave (
        input  req_valid, req_vsew, req_vlmul, req_vl, req_vstart,
               req_use_mask, req_mask, req_is_reduct, out_ready,
        output req_ready, out_valid, out_reg_idx, out_elem_valid,
               out_merge, out_osize, out_last, out_illegal
    );
endinterface

// File: rtl/riscv_v_decode_lmul_sequencer.sv
// Splits one vector instruction (vsew/vlmul/vl/vstart/mask) into one beat
// per register of the group. Each beat carries byte-granular element-valid
// bits and carry-chain merge bits for a DATA_BYTES-wide datapath.
module riscv_v_decode_lmul_sequencer #(
    parameter int DATA_BYTES = 16,
    parameter int MAX_LMUL   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    riscv_v_decode_lmul_sequencer_if.slave        bus,
    output logic                                  dbg_state_o
);
    localparam int TOTAL  = DATA_BYTES * MAX_LMUL;
    localparam int VL_W   = $clog2(TOTAL + 1);
    localparam int IDX_W  = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1;
    localparam int MI_W   = $clog2(TOTAL);
    localparam int CW     = VL_W + 2;
    localparam int DB_LOG = $clog2(DATA_BYTES);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    logic [2:0]        vsew_q;
    logic [1:0]        vlmul_q;
    logic [VL_W-1:0]   vl_q;
    logic [VL_W-1:0]   vstart_q;
    logic              use_mask_q;
    logic [TOTAL-1:0]  mask_q;
    logic              reduct_q;

    logic              illegal_c;
    logic [2:0]        sew_sh;
    logic [CW-1:0]     epr, lmul, vlmax, vl_ext, vstart_ext, vl_eff;
    logic [CW-1:0]     nb_raw, last_idx;
    logic              empty_c, single_c, last_c;

    logic [CW-1:0]     esz_m1, g;
    logic              in_rng, mask_bit;
    logic [DATA_BYTES-1:0] elem_valid_c, merge_c;

    // State register and request capture; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            vsew_q     <= '0;
            vlmul_q    <= '0;
            vl_q       <= '0;
            vstart_q   <= '0;
            use_mask_q <= 1'b0;
            mask_q     <= '0;
            reduct_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                vsew_q     <= bus.req_vsew;
                vlmul_q    <= bus.req_vlmul;
                vl_q       <= bus.req_vl;
                vstart_q   <= bus.req_vstart;
                use_mask_q <= bus.req_use_mask;
                mask_q     <= bus.req_mask;
                reduct_q   <= bus.req_is_reduct;
            end
        end
    end

    // Next state: accept only from IDLE, advance the beat counter per handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (bus.out_ready) begin
                    if (last_c) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Group geometry: elements per register, effective vl and the last beat index.
    always_comb begin
        illegal_c  = (vsew_q > 3'd4) || ((CW'(1) << vlmul_q) > CW'(MAX_LMUL));
        // an illegal vsew would shift EPR to zero; park it at 8-bit instead
        sew_sh     = illegal_c ? 3'd0 : vsew_q;
        epr        = CW'(DATA_BYTES) >> sew_sh;
        lmul       = CW'(1) << vlmul_q;
        vlmax      = epr * lmul;
        vl_ext     = CW'(vl_q);
        vstart_ext = CW'(vstart_q);
        vl_eff     = (vl_ext < vlmax) ? vl_ext : vlmax;
        // ceil(vl_eff / EPR); EPR is a power of two so this is a shift
        nb_raw     = (vl_eff + epr - CW'(1)) >> (CW'(DB_LOG) - CW'(sew_sh));
        empty_c    = (vl_eff == '0) || (vstart_ext >= vl_eff);
        single_c   = illegal_c || empty_c || reduct_q;
        last_idx   = single_c ? '0 : (nb_raw - CW'(1));
        last_c     = (CW'(cnt_q) == last_idx);
    end

    // Per-byte element activity and carry-merge bits for the current beat.
    always_comb begin
        elem_valid_c = '0;
        merge_c      = '0;
        g            = '0;
        in_rng       = 1'b0;
        mask_bit     = 1'b0;
        esz_m1       = (CW'(1) << sew_sh) - CW'(1);
        for (int b = 0; b < DATA_BYTES; b++) begin
            g        = CW'(cnt_q) * epr + (CW'(b) >> sew_sh);
            in_rng   = (g >= vstart_ext) && (g < vl_eff);
            mask_bit = (g < CW'(TOTAL)) ? mask_q[g[MI_W-1:0]] : 1'b0;
            elem_valid_c[b] = in_rng && (!use_mask_q || mask_bit) &&
                              (!reduct_q || (g == '0)) && !illegal_c;
            // every byte but the element's top byte passes carry upward
            merge_c[b] = ((CW'(b) & esz_m1) != esz_m1) && !illegal_c;
        end
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.out_valid      = (state_q == ISSUE);
    assign bus.out_reg_idx    = cnt_q;
    assign bus.out_elem_valid = (state_q == ISSUE) ? elem_valid_c : '0;
    assign bus.out_merge      = (state_q == ISSUE) ? merge_c : '0;
    assign bus.out_osize      = vsew_q;
    assign bus.out_last       = (state_q == ISSUE) && last_c;
    assign bus.out_illegal    = (state_q == ISSUE) && illegal_c;
    assign dbg_state_o        = (state_q == ISSUE);

endmodule

// File: tb/tb_riscv_v_decode_lmul_sequencer.sv
// Bench for riscv_v_decode_lmul_sequencer at DATA_BYTES=16, MAX_LMUL=8.
`timescale 1ns/1ps
module tb_riscv_v_decode_lmul_sequencer;
    localparam int DB = 16;
    localparam int ML = 8;
    localparam int VW = 8;
    localparam int IW = 3;
    localparam int BW = IW + DB + DB + 3 + 1 + 1;
    localparam int NV = 13;

    typedef struct packed {
        logic [2:0]       vsew;
        logic [1:0]       vlmul;
        logic [VW-1:0]    vl;
        logic [VW-1:0]    vstart;
        logic             use_mask;
        logic [DB*ML-1:0] mask;
        logic             reduct;
        logic [3:0]       nb;
        logic             ill;
        logic [8*DB-1:0]  ev;
        logic [DB-1:0]    mg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;
    int   checks = 0;
    int   errors = 0;
    int   bp_mode = 0;
    logic [BW-1:0] exp_q[$];
    vec_t tbl[NV];
    logic [BW-1:0] snap;

    riscv_v_decode_lmul_sequencer_if #(.DATA_BYTES(DB), .MAX_LMUL(ML)) bus ();

    riscv_v_decode_lmul_sequencer #(.DATA_BYTES(DB), .MAX_LMUL(ML)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // consumer back-pressure: 0 always ready, 1 random, 2 stalled
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    function automatic logic [BW-1:0] pack(input logic [IW-1:0] idx, input logic [DB-1:0] ev,
                                           input logic [DB-1:0] mg, input logic [2:0] os,
                                           input logic last, input logic ill);
        return {idx, ev, mg, os, last, ill};
    endfunction

    function automatic vec_t mkv(input logic [2:0] vsew, input logic [1:0] vlmul,
                                 input logic [VW-1:0] vl, input logic [VW-1:0] vstart,
                                 input logic um, input logic [DB*ML-1:0] mask,
                                 input logic red, input logic [3:0] nb, input logic ill,
                                 input logic [8*DB-1:0] ev, input logic [DB-1:0] mg);
        vec_t v;
        v.vsew = vsew; v.vlmul = vlmul; v.vl = vl; v.vstart = vstart;
        v.use_mask = um; v.mask = mask; v.reduct = red; v.nb = nb;
        v.ill = ill; v.ev = ev; v.mg = mg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compares every accepted beat, checks stall stability
    logic [BW-1:0] prev_beat;
    logic          prev_stall = 1'b0;
    always @(negedge clk) begin
        logic [BW-1:0] act;
        act = pack(bus.out_reg_idx, bus.out_elem_valid, bus.out_merge,
                   bus.out_osize, bus.out_last, bus.out_illegal);
        if (rst_n === 1'b1) begin
            if (prev_stall) begin
                chk("stall_hold_valid", bus.out_valid, 1);
                chk("stall_hold_fields", act, prev_beat);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", act);
                end else begin
                    chk("beat", act, exp_q.pop_front());
                end
            end
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_beat  = act;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // driver: present one request, queue its expected beats, return at the
    // negedge after acceptance
    task automatic send(input vec_t v);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready=%b expected 1", bus.req_ready);
            return;
        end
        bus.req_vsew      = v.vsew;
        bus.req_vlmul     = v.vlmul;
        bus.req_vl        = v.vl;
        bus.req_vstart    = v.vstart;
        bus.req_use_mask  = v.use_mask;
        bus.req_mask      = v.mask;
        bus.req_is_reduct = v.reduct;
        bus.req_valid     = 1'b1;
        for (int k = 0; k < int'(v.nb); k++)
            exp_q.push_back(pack(IW'(k), v.ev[k*DB +: DB], v.mg, v.vsew,
                                 (k == int'(v.nb) - 1), v.ill));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("accept_latency_valid", bus.out_valid, 1);
        chk("no_reaccept_ready", bus.req_ready, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.req_ready !== 1'b1) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_reg_idx"}, bus.out_reg_idx, 0);
        chk({tag, "_elem_valid"}, bus.out_elem_valid, 0);
        chk({tag, "_merge"}, bus.out_merge, 0);
        chk({tag, "_osize"}, bus.out_osize, 0);
        chk({tag, "_last"}, bus.out_last, 0);
        chk({tag, "_illegal"}, bus.out_illegal, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_vsew = '0; bus.req_vlmul = '0;
        bus.req_vl = '0; bus.req_vstart = '0; bus.req_use_mask = 1'b0;
        bus.req_mask = '0; bus.req_is_reduct = 1'b0;

        // vsew vlmul vl vstart um mask red nb ill ev{beatN..beat0} merge
        tbl[0]  = mkv(3'd2, 2'd1, 8'd6,   8'd0, 1'b0, '0,     1'b0, 4'd2, 1'b0, {16'h00FF, 16'hFFFF}, 16'h7777);
        tbl[1]  = mkv(3'd0, 2'd0, 8'd16,  8'd3, 1'b1, 128'hFF, 1'b0, 4'd1, 1'b0, 16'h00F8, 16'h0000);
        tbl[2]  = mkv(3'd3, 2'd3, 8'd5,   8'd0, 1'b0, '0,     1'b0, 4'd3, 1'b0, {16'h00FF, 16'hFFFF, 16'hFFFF}, 16'h7F7F);
        tbl[3]  = mkv(3'd2, 2'd0, 8'd0,   8'd0, 1'b0, '0,     1'b0, 4'd1, 1'b0, 16'h0000, 16'h7777);
        tbl[4]  = mkv(3'd5, 2'd0, 8'd4,   8'd0, 1'b0, '0,     1'b0, 4'd1, 1'b1, 16'h0000, 16'h0000);
        tbl[5]  = mkv(3'd1, 2'd1, 8'd8,   8'd8, 1'b0, '0,     1'b0, 4'd1, 1'b0, 16'h0000, 16'h5555);
        tbl[6]  = mkv(3'd2, 2'd0, 8'd20,  8'd0, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF5,
                      1'b0, 4'd1, 1'b0, 16'h0F0F, 16'h7777);
        tbl[7]  = mkv(3'd2, 2'd2, 8'd10,  8'd0, 1'b0, '0,     1'b1, 4'd1, 1'b0, 16'h000F, 16'h7777);
        tbl[8]  = mkv(3'd0, 2'd1, 8'd20,  8'd0, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA_5555,
                      1'b0, 4'd2, 1'b0, {16'h000A, 16'h5555}, 16'h0000);
        tbl[9]  = mkv(3'd4, 2'd2, 8'd3,   8'd1, 1'b0, '0,     1'b0, 4'd3, 1'b0, {16'hFFFF, 16'hFFFF, 16'h0000}, 16'h7FFF);
        tbl[10] = mkv(3'd1, 2'd3, 8'd100, 8'd0, 1'b0, '0,     1'b0, 4'd8, 1'b0, {8{16'hFFFF}}, 16'h5555);
        tbl[11] = mkv(3'd6, 2'd3, 8'd9,   8'd0, 1'b0, '0,     1'b0, 4'd1, 1'b1, 16'h0000, 16'h0000);
        tbl[12] = mkv(3'd3, 2'd1, 8'd4,   8'd3, 1'b0, '0,     1'b0, 4'd2, 1'b0, {16'hFF00, 16'h0000}, 16'h7F7F);

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // table vectors under random back-pressure
        bp_mode = 1;
        for (int i = 0; i < NV; i++) begin
            send(tbl[i]);
            wait_idle();
        end

        // stall on beat 0 for 3 cycles while a second request is offered
        bp_mode = 2;
        send(tbl[0]);
        snap = pack(bus.out_reg_idx, bus.out_elem_valid, bus.out_merge,
                    bus.out_osize, bus.out_last, bus.out_illegal);
        chk("stall_beat0", snap, pack(3'd0, 16'hFFFF, 16'h7777, 3'd2, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.req_vsew = 3'd0; bus.req_vlmul = 2'd0; bus.req_vl = 8'd16;
            bus.req_vstart = 8'd0; bus.req_use_mask = 1'b0; bus.req_is_reduct = 1'b0;
            bus.req_valid = 1'b1;
            @(negedge clk);
            chk("stall_fields", pack(bus.out_reg_idx, bus.out_elem_valid, bus.out_merge,
                                     bus.out_osize, bus.out_last, bus.out_illegal), snap);
            chk("stall_req_ready", bus.req_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bp_mode = 0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        // back to IDLE the cycle after the last handshake
        send(tbl[3]);
        @(posedge clk);
        @(negedge clk);
        chk("post_last_req_ready", bus.req_ready, 1);
        chk("post_last_out_valid", bus.out_valid, 0);
        chk("post_last_state", dbg_state, 0);
        @(posedge clk); #1;

        // reset while beat 1 is presented: the request is dropped
        send(tbl[0]);
        @(posedge clk); #1;
        chk("pre_reset_beat1_idx", bus.out_reg_idx, 1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        reset_check("midreset");
        repeat (6) @(posedge clk);
        #1;

        // recovery after reset
        bp_mode = 1;
        send(tbl[2]);
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
